alu_mdu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 3-bit-function ALU, for the multicycle MIPS datapath.
- Keeps the AND/OR/ADD/SUB/SLT encoding: F[2] inverts B and supplies carry-in, F[1:0] selects the result.
- Adds unsigned multiply and divide into internal HI/LO registers, read back with MFHI/MFLO.
- All results are registered. A start/ready/done handshake lets the controller stall on long operations.

---
 rtl/alu_mdu_if.sv | 25 ++
 rtl/alu_mdu.sv | 177 +++++++++++++++++
 tb/tb_alu_mdu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the multicycle controller and alu_mdu.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       F;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             Zero;
    logic             Ovf;
    logic             DivZero;

    modport master (
        output start, F, A, B,
        input  ready, done, Y, Zero, Ovf, DivZero
    );

    modport slave (
        input  start, F, A, B,
        output ready, done, Y, Zero, Ovf, DivZero
    );
endinterface

// File: rtl/alu_mdu.sv
// Multi-cycle ALU with unsigned multiply/divide into HI/LO.
// Single-cycle ops complete on the accept edge; MULTU/DIVU iterate WIDTH edges.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input logic     clk,
    input logic     reset,
    alu_mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             divz_q, divz_d;

    logic [WIDTH-1:0] bb, sum, alu_y;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;

    // Single-cycle datapath: F[2] inverts B and feeds carry-in.
    always_comb begin
        bb      = bus.F[2] ? ~bus.B : bus.B;
        sum     = bus.A + bb + {{(WIDTH-1){1'b0}}, bus.F[2]};
        alu_ovf = 1'b0;
        alu_y   = '0;
        if (!bus.F[3]) begin
            case (bus.F[1:0])
                2'b00: alu_y = bus.A & bb;
                2'b01: alu_y = bus.A | bb;
                2'b10: alu_y = sum;
                2'b11: alu_y = bus.F[2] ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1]} : sum;
            endcase
            if (bus.F[1:0] == 2'b10 || bus.F[2:0] == 3'b011)
                alu_ovf = (bus.A[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
        end else if (bus.F[2:0] == 3'b010) begin
            alu_y = hi_q;
        end else if (bus.F[2:0] == 3'b011) begin
            alu_y = lo_q;
        end
    end

    // One shift-add step (LSB-first) and one restoring-divide step (MSB-first).
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + {1'b0, (opb_q[0] ? opa_q : {WIDTH{1'b0}})};
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        // Remainder stays below B, so the top bit of the difference is the borrow.
        // With B == 0 every step succeeds: quotient all ones, remainder ends as A.
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_ok   = ~div_diff[WIDTH];
        div_hi_n = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_lo_n = {acc_lo_q[WIDTH-2:0], div_ok};
    end

    // Control FSM and next-state for all registers.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        divz_d   = divz_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.F == 4'b1000 || bus.F == 4'b1001) begin
                        opa_d    = bus.A;
                        opb_d    = bus.B;
                        acc_hi_d = '0;
                        acc_lo_d = (bus.F[0]) ? bus.A : '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = bus.F[0] ? DIV : MUL;
                    end else begin
                        y_d    = alu_y;
                        zero_d = (alu_y == '0);
                        ovf_d  = alu_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                opb_d    = opb_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = mul_hi_n;
                    lo_d    = mul_lo_n;
                    y_d     = mul_lo_n;
                    zero_d  = (mul_lo_n == '0);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV: begin
                acc_hi_d = div_hi_n;
                acc_lo_d = div_lo_n;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = div_hi_n;
                    lo_d    = div_lo_n;
                    y_d     = div_lo_n;
                    zero_d  = (div_lo_n == '0);
                    ovf_d   = 1'b0;
                    divz_d  = (opb_q == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            divz_q   <= divz_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.done    = done_q;
    assign bus.Y       = y_q;
    assign bus.Zero    = zero_q;
    assign bus.Ovf     = ovf_q;
    assign bus.DivZero = divz_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Randomized + directed bench for alu_mdu at WIDTH=32 and WIDTH=8.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) b32 ();
    alu_mdu_if #(.WIDTH(8))  b8 ();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    int nvec = 0;
    int nbad = 0;

    // Observations indexed by width select (0: 32-bit, 1: 8-bit).
    logic [1:0]  o_ready, o_done, o_zero, o_ovf, o_dz;
    logic [31:0] o_y [2];
    assign o_ready = {b8.ready, b32.ready};
    assign o_done  = {b8.done, b32.done};
    assign o_zero  = {b8.Zero, b32.Zero};
    assign o_ovf   = {b8.Ovf, b32.Ovf};
    assign o_dz    = {b8.DivZero, b32.DivZero};
    assign o_y[0]  = b32.Y;
    assign o_y[1]  = {24'b0, b8.Y};

    // Reference architectural state.
    logic [31:0] hi_m [2];
    logic [31:0] lo_m [2];
    logic        dz_m [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic s, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            b8.start = s; b8.F = f; b8.A = a[7:0]; b8.B = b[7:0];
        end else begin
            b32.start = s; b32.F = f; b32.A = a; b32.B = b;
        end
    endtask

    // Architectural model: plain arithmetic on 64-bit integers.
    task automatic model(input bit w8, input logic [3:0] f, input logic [31:0] a_i,
                         input logic [31:0] b_i, output logic [31:0] y, output logic ovf,
                         output bit multi);
        int w;
        longint unsigned m, a, b, p;
        longint sa, sb, s, smax, smin;
        w    = w8 ? 8 : 32;
        m    = (64'd1 << w) - 1;
        a    = {32'b0, a_i} & m;
        b    = {32'b0, b_i} & m;
        sa   = ((a >> (w-1)) & 1) != 0 ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = ((b >> (w-1)) & 1) != 0 ? longint'(b) - (longint'(1) << w) : longint'(b);
        smax = (longint'(1) << (w-1)) - 1;
        smin = -(longint'(1) << (w-1));
        s    = 0;
        y    = '0;
        ovf  = 1'b0;
        multi = 1'b0;
        case (f)
            4'b0000: y = 32'(a & b);
            4'b0001: y = 32'(a | b);
            4'b0100: y = 32'(a & ~b & m);
            4'b0101: y = 32'((a | ~b) & m);
            4'b0010, 4'b0011: begin
                y = 32'((a + b) & m); s = sa + sb; ovf = (s > smax) || (s < smin);
            end
            4'b0110: begin
                y = 32'((a - b) & m); s = sa - sb; ovf = (s > smax) || (s < smin);
            end
            4'b0111: y = 32'(((a - b) & m) >> (w-1));
            4'b1000: begin
                p = a * b;
                hi_m[w8] = 32'(p >> w); lo_m[w8] = 32'(p & m);
                y = lo_m[w8]; multi = 1'b1;
            end
            4'b1001: begin
                if (b == 0) begin
                    lo_m[w8] = 32'(m); hi_m[w8] = 32'(a); dz_m[w8] = 1'b1;
                end else begin
                    lo_m[w8] = 32'(a / b); hi_m[w8] = 32'(a % b); dz_m[w8] = 1'b0;
                end
                y = lo_m[w8]; multi = 1'b1;
            end
            4'b1010: y = hi_m[w8];
            4'b1011: y = lo_m[w8];
            default: y = '0;
        endcase
    endtask

    // Issue one op, optionally pulse a stray ADD start at busy cycle 'poke'.
    task automatic do_op(input bit w8, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int poke);
        logic [31:0] ey;
        logic eovf;
        bit   multi;
        int   n, nrdy, g, w;
        w = w8 ? 8 : 32;
        model(w8, f, a, b, ey, eovf, multi);
        @(negedge clk);
        g = 0;
        while (!o_ready[w8] && g < 100) begin @(negedge clk); g++; end
        if (g == 100) chk("ready_timeout", 0, 1);
        drive(w8, 1'b1, f, a, b);
        n = 0; nrdy = 0;
        do begin
            @(negedge clk);
            n++;
            if (!o_ready[w8]) nrdy++;
            if (n == poke) drive(w8, 1'b1, 4'b0010, $urandom, $urandom);
            else           drive(w8, 1'b0, 4'($urandom), $urandom, $urandom);
        end while (!o_done[w8] && n < 100);
        chk($sformatf("done f=%b", f), o_done[w8], 1);
        chk($sformatf("lat f=%b", f), n, multi ? w + 1 : 1);
        chk($sformatf("busy f=%b", f), nrdy, multi ? w : 0);
        chk($sformatf("Y f=%b a=%h b=%h", f, a, b), o_y[w8], ey);
        chk($sformatf("Zero f=%b", f), o_zero[w8], ey == 0);
        chk($sformatf("Ovf f=%b a=%h b=%h", f, a, b), o_ovf[w8], eovf);
        chk($sformatf("DivZero f=%b", f), o_dz[w8], dz_m[w8]);
        if (multi) begin
            @(negedge clk);
            chk("done_once", o_done[w8], 0);
        end
    endtask

    task automatic chk_reset(input bit w8);
        chk("rst_ready", o_ready[w8], 1);
        chk("rst_done", o_done[w8], 0);
        chk("rst_Y", o_y[w8], 0);
        chk("rst_Zero", o_zero[w8], 1);
        chk("rst_Ovf", o_ovf[w8], 0);
        chk("rst_DivZero", o_dz[w8], 0);
        hi_m[w8] = '0; lo_m[w8] = '0; dz_m[w8] = 1'b0;
    endtask

    initial begin
        logic [3:0] f;
        bit w8;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);

        // Directed, WIDTH=32.
        do_op(0, 4'b0010, 32'h7FFFFFFF, 32'h1, -1);
        do_op(0, 4'b0110, 32'd5, 32'd5, -1);
        do_op(0, 4'b0111, 32'hFFFFFFFE, 32'h1, -1);
        do_op(0, 4'b0111, 32'd3, 32'd2, -1);

        // Back-to-back AND then OR.
        @(negedge clk);
        drive(0, 1, 4'b0000, 32'hFF0F, 32'h0F00);
        @(negedge clk);
        chk("b2b_done0", o_done[0], 1);
        chk("b2b_and", o_y[0], 32'h0F00);
        drive(0, 1, 4'b0001, 32'hFF0F, 32'h0F00);
        @(negedge clk);
        chk("b2b_done1", o_done[0], 1);
        chk("b2b_or", o_y[0], 32'hFF0F);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_idle", o_done[0], 0);

        do_op(0, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        do_op(0, 4'b1010, 0, 0, -1);
        do_op(0, 4'b1001, 32'd100, 32'd7, -1);
        do_op(0, 4'b1010, 0, 0, -1);
        do_op(0, 4'b1001, 32'd9, 32'd0, -1);
        do_op(0, 4'b1010, 0, 0, -1);
        do_op(0, 4'b1000, $urandom, $urandom, 5);
        do_op(0, 4'b1010, 0, 0, -1);
        do_op(0, 4'b1011, 0, 0, -1);

        // Reset in the middle of a DIVU.
        @(negedge clk);
        drive(0, 1, 4'b1001, $urandom, 32'd3);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset(0);
        chk_reset(1);
        do_op(0, 4'b1010, 0, 0, -1);
        do_op(0, 4'b1011, 0, 0, -1);

        // Directed, WIDTH=8.
        do_op(1, 4'b1000, 32'hFF, 32'hFF, -1);
        do_op(1, 4'b1010, 0, 0, -1);
        do_op(1, 4'b1001, 32'd200, 32'd7, 5);
        do_op(1, 4'b1010, 0, 0, -1);
        do_op(1, 4'b1001, 32'd9, 32'd0, -1);
        do_op(1, 4'b1010, 0, 0, -1);
        do_op(1, 4'b0010, 32'h7F, 32'h01, -1);

        // Random mix across both widths; small operands now and then for edge cases.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            w8 = 1'($urandom_range(0, 1));
            f  = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = b;
            do_op(w8, f, a, b, ($urandom_range(0, 3) == 0) ? 3 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
